// File: rtl/lcd_seq_pkg.sv
// Shared encodings for the 9-bit 3-wire LCD sequencer: init ROM word types,
// sequencer FSM states and the serial frame length.
package lcd_seq_pkg;

  localparam logic [1:0] ROM_CMD  = 2'b00;
  localparam logic [1:0] ROM_DATA = 2'b01;
  localparam logic [1:0] ROM_DLY  = 2'b10;
  localparam logic [1:0] ROM_END  = 2'b11;

  localparam int unsigned FRAME_BITS = 9;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StShift,
    StGap,
    StDelay,
    StRun
  } seq_state_e;

endpackage

// File: rtl/lcd_spi9_shifter.sv
// Serialises one {dc, byte} frame MSB-first on a CPOL=0 link, then holds CS high
// for the inter-frame gap. frame_end_o marks the last shift cycle, done_o the last gap cycle.
module lcd_spi9_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       dc_i,
  input  logic [7:0] byte_i,
  output logic       frame_end_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       cs_n_o,
  output logic       mosi_o
);
  import lcd_seq_pkg::*;

  localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
  localparam logic [DivW-1:0] HalfLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] GapLast  = DivW'(2 * CLK_DIV - 1);
  localparam logic [DivW-1:0] DivOne   = DivW'(1);
  localparam logic [3:0]      BitLast  = 4'(FRAME_BITS - 1);

  logic            shifting_q, shifting_d;
  logic            gap_q, gap_d;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      sr_q, sr_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic            half_end;

  assign half_end    = (div_q == HalfLast);
  assign frame_end_o = shifting_q && half_end && sclk_q && (bit_q == BitLast);
  assign done_o      = gap_q && (div_q == GapLast);
  assign sclk_o      = sclk_q;
  assign cs_n_o      = cs_n_q;
  assign mosi_o      = mosi_q;

  always_comb begin
    shifting_d = shifting_q;
    gap_d      = gap_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    if (start_i) begin
      shifting_d = 1'b1;
      gap_d      = 1'b0;
      div_d      = '0;
      bit_d      = '0;
      sr_d       = byte_i;
      sclk_d     = 1'b0;
      cs_n_d     = 1'b0;
      mosi_d     = dc_i;
    end else if (shifting_q) begin
      if (half_end) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        // Data only changes on the falling edge so the panel sees it stable at the rise.
        if (sclk_q) begin
          if (bit_q == BitLast) begin
            shifting_d = 1'b0;
            gap_d      = 1'b1;
            cs_n_d     = 1'b1;
            mosi_d     = 1'b0;
            bit_d      = '0;
          end else begin
            bit_d  = bit_q + 4'd1;
            mosi_d = sr_q[7];
            sr_d   = {sr_q[6:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + DivOne;
      end
    end else if (gap_q) begin
      if (done_o) begin
        gap_d = 1'b0;
        div_d = '0;
      end else begin
        div_d = div_q + DivOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shifting_q <= 1'b0;
      gap_q      <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      shifting_q <= shifting_d;
      gap_q      <= gap_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// LCD link sequencer: plays the panel init ROM (commands, data, delays), then hands
// the 9-bit serial link to the host byte stream, switching owners only between frames.
module lcd_spi_sequencer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned ROM_AW     = 8,
  parameter int unsigned DELAY_UNIT = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              init_start,
  output logic              init_done,
  output logic              busy,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_dc,
  input  logic [7:0]        host_data,
  output logic              lcd_sclk,
  output logic              lcd_cs_n,
  output logic              lcd_mosi
);
  import lcd_seq_pkg::*;

  localparam int unsigned DlyW = 8 + $clog2(DELAY_UNIT);
  localparam logic [DlyW-1:0]   DlyUnit = DlyW'(DELAY_UNIT);
  localparam logic [DlyW-1:0]   DlyOne  = DlyW'(1);
  localparam logic [ROM_AW-1:0] AddrOne = ROM_AW'(1);

  seq_state_e        state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic [DlyW-1:0]   dly_q, dly_d;
  logic              from_host_q, from_host_d;
  logic              pend_q, pend_d;
  logic              advance;
  logic              sh_start, sh_dc;
  logic [7:0]        sh_byte;
  logic              frame_end, frame_done;
  logic [1:0]        rom_type;
  logic [7:0]        rom_arg;

  assign rom_type  = rom_data[9:8];
  assign rom_arg   = rom_data[7:0];
  assign rom_addr  = addr_q;
  assign init_done = done_q;
  assign busy      = (state_q != StIdle) && (state_q != StRun);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    done_d      = done_q;
    dly_d       = dly_q;
    from_host_d = from_host_q;
    pend_d      = pend_q;
    advance     = 1'b0;
    sh_start    = 1'b0;
    sh_dc       = host_dc;
    sh_byte     = host_data;
    host_ready  = (state_q == StRun) && !init_start;

    unique case (state_q)
      StIdle: begin
        if (init_start) begin
          state_d = StFetch;
          addr_d  = '0;
          done_d  = 1'b0;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (rom_type)
          ROM_CMD, ROM_DATA: begin
            sh_start    = 1'b1;
            sh_dc       = rom_type[0];
            sh_byte     = rom_arg;
            from_host_d = 1'b0;
            state_d     = StShift;
          end
          ROM_DLY: begin
            if (rom_arg == 8'd0) begin
              advance = 1'b1;
            end else begin
              dly_d   = DlyW'(rom_arg) * DlyUnit - DlyOne;
              state_d = StDelay;
            end
          end
          ROM_END: begin
            done_d  = 1'b1;
            state_d = StRun;
          end
        endcase
      end
      StDelay: begin
        if (dly_q == '0) advance = 1'b1;
        else             dly_d   = dly_q - DlyOne;
      end
      StShift: begin
        if (from_host_q && init_start) pend_d = 1'b1;
        if (frame_end) state_d = StGap;
      end
      StGap: begin
        if (from_host_q && init_start) pend_d = 1'b1;
        if (frame_done) begin
          if (!from_host_q) begin
            advance = 1'b1;
          end else if (pend_q || init_start) begin
            pend_d  = 1'b0;
            state_d = StFetch;
            addr_d  = '0;
            done_d  = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (init_start) begin
          state_d = StFetch;
          addr_d  = '0;
          done_d  = 1'b0;
        end else if (host_valid) begin
          sh_start    = 1'b1;
          from_host_d = 1'b1;
          state_d     = StShift;
        end
      end
      default: state_d = StIdle;
    endcase

    // The last ROM address ends the sequence rather than wrapping back to 0.
    if (advance) begin
      if (&addr_q) begin
        done_d  = 1'b1;
        state_d = StRun;
      end else begin
        addr_d  = addr_q + AddrOne;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      done_q      <= 1'b0;
      dly_q       <= '0;
      from_host_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      dly_q       <= dly_d;
      from_host_q <= from_host_d;
      pend_q      <= pend_d;
    end
  end

  lcd_spi9_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .start_i    (sh_start),
    .dc_i       (sh_dc),
    .byte_i     (sh_byte),
    .frame_end_o(frame_end),
    .done_o     (frame_done),
    .sclk_o     (lcd_sclk),
    .cs_n_o     (lcd_cs_n),
    .mosi_o     (lcd_mosi)
  );

endmodule
